// File: rtl/decode_stage.sv
// decode_stage: RV32I decode with register file, load-use stall, flush and writeback bypass
module decode_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h00000013,
  parameter int REG_NUM = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_to_d_valid,
  output logic        d_allow_in,
  input  logic [31:0] f_pc,
  input  logic [31:0] f_default_pc,
  input  logic [31:0] f_instr,
  input  logic [6:0]  f_opcode,
  input  logic [4:0]  f_rd,
  input  logic [4:0]  f_rs1,
  input  logic [4:0]  f_rs2,
  input  logic [9:0]  f_funct,
  input  logic [31:0] f_imm,
  input  logic [2:0]  f_instr_type,
  input  logic        e_allow_in,
  output logic        d_to_e_valid,
  input  logic        e_valid,
  input  logic        can_jump,
  input  logic        e_is_load,
  input  logic [4:0]  e_rd,
  input  logic        w_en,
  input  logic [4:0]  w_rd,
  input  logic [31:0] w_data,
  output logic [31:0] d_pc,
  output logic [31:0] d_default_pc,
  output logic [31:0] d_instr,
  output logic [6:0]  d_opcode,
  output logic [4:0]  d_rd,
  output logic [4:0]  d_rs1,
  output logic [4:0]  d_rs2,
  output logic [9:0]  d_funct,
  output logic [31:0] d_imm,
  output logic [2:0]  d_instr_type,
  output logic [31:0] d_src1,
  output logic [31:0] d_src2,
  output logic        d_reg_we
);
  localparam logic [2:0] TYPER = 3'd1, TYPEI = 3'd2, TYPES = 3'd3, TYPEB = 3'd4;
  logic        d_valid;
  logic [31:0] rf [REG_NUM];
  logic        flush, uses_rs1, uses_rs2, hazard, wr;
  assign flush    = e_valid && can_jump;
  assign uses_rs1 = d_instr_type inside {TYPER, TYPEI, TYPES, TYPEB};
  assign uses_rs2 = d_instr_type inside {TYPER, TYPES, TYPEB};
  assign hazard   = d_valid && e_valid && e_is_load && e_rd != '0 &&
                    ((uses_rs1 && e_rd == d_rs1) || (uses_rs2 && e_rd == d_rs2));
  assign d_allow_in   = !d_valid || (!hazard && e_allow_in);
  assign d_to_e_valid = d_valid && !hazard && !flush;
  assign wr           = w_en && w_rd != '0;
  assign d_src1   = d_rs1 == '0 ? '0 : (wr && w_rd == d_rs1) ? w_data : rf[d_rs1];
  assign d_src2   = d_rs2 == '0 ? '0 : (wr && w_rd == d_rs2) ? w_data : rf[d_rs2];
  assign d_reg_we = d_rd != '0 && d_instr_type != TYPES && d_instr_type != TYPEB;
  always_ff @(posedge clk) begin
    if (rst) d_valid <= 1'b0;
    else if (flush) d_valid <= 1'b0;
    else if (d_allow_in) d_valid <= f_to_d_valid;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      d_pc         <= '0;
      d_default_pc <= '0;
      d_instr      <= NOP_INSTR;
      d_opcode     <= 7'h13;
      d_rd         <= '0;
      d_rs1        <= '0;
      d_rs2        <= '0;
      d_funct      <= '0;
      d_imm        <= '0;
      d_instr_type <= '0;
    end else if (d_allow_in && f_to_d_valid && !flush) begin
      d_pc         <= f_pc;
      d_default_pc <= f_default_pc;
      d_instr      <= f_instr;
      d_opcode     <= f_opcode;
      d_rd         <= f_rd;
      d_rs1        <= f_rs1;
      d_rs2        <= f_rs2;
      d_funct      <= f_funct;
      d_imm        <= f_imm;
      d_instr_type <= f_instr_type;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) for (int i = 0; i < REG_NUM; i++) rf[i] <= '0;
    else if (wr) rf[w_rd] <= w_data;
  end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Second stage of the 5-stage RV32I pipeline. It sits directly downstream of fetch_stage. Each cycle it latches the pre-decoded fetch fields through a valid/allow_in handshake and holds the 32x32 integer register file. It produces operand values for execute, inserts a bubble on load-use hazards, and drops wrong-path instructions when execute resolves a taken branch.

Parameters:
NOP_INSTR, 32'h00000013, instruction word held in d_instr at reset/flush (addi x0,x0,0)
REG_NUM, 32, register file depth; x0 hardwired zero

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous, active-high reset
f_to_d_valid  in  1  fetch holds a valid instruction
d_allow_in  out  1  decode accepts a new instruction this cycle
f_pc, f_default_pc, f_instr  in  32 each  fetch PC, PC+4, raw instruction
f_opcode, f_rd, f_rs1, f_rs2  in  7/5/5/5  pre-decoded fields from fetch
f_funct, f_imm, f_instr_type  in  10/32/3  pre-decoded fields from fetch
e_allow_in  in  1  execute accepts an instruction this cycle
d_to_e_valid  out  1  decode presents a valid instruction to execute
e_valid, can_jump  in  1 each  execute holds a valid, taken branch/jump (flush request)
e_is_load, e_rd  in  1/5  instruction in execute is a load and its destination
w_en, w_rd, w_data  in  1/5/32  writeback port into the register file
d_pc, d_default_pc, d_instr  out  32 each  registered copies
d_opcode, d_rd, d_rs1, d_rs2, d_funct, d_imm, d_instr_type  out  7/5/5/5/10/32/3  registered copies
d_src1, d_src2  out  32 each  rs1/rs2 read data, with writeback bypass
d_reg_we  out  1  instruction writes rd: rd!=0 and type not TYPES/TYPEB

Behaviour:
- Reset (rst=1 at posedge):
  - d_valid<=0.
  - All registered payload <=0, except d_instr<=NOP_INSTR and d_opcode<=7'h13.
  - All registers x0..x31 <=0.
  - d_to_e_valid=0 and d_allow_in=1 in the following cycle.
- flush = e_valid && can_jump.
- uses_rs1 = type in {TYPER, TYPEI, TYPES, TYPEB}.
- uses_rs2 = type in {TYPER, TYPES, TYPEB}.
- hazard = d_valid && e_valid && e_is_load && e_rd!=0 && ((uses_rs1 && e_rd==d_rs1) || (uses_rs2 && e_rd==d_rs2)).
- d_ready_go = ~hazard.
- d_allow_in = ~d_valid || (d_ready_go && e_allow_in). Combinational, no dependence on f_to_d_valid.
- d_to_e_valid = d_valid && d_ready_go && ~flush. Combinational, so a flush kills the wrong-path instruction in the same cycle.
- d_valid update priority at posedge: rst, then flush (->0), then d_allow_in (->f_to_d_valid), else hold.
- Payload captured only when d_allow_in && f_to_d_valid && ~flush. Otherwise held unchanged, including during stalls and back-pressure.
- Flush beats stall: flush during a load-use stall clears d_valid. The instruction fetch presents in the flush cycle is dropped; fetch redirects its PC on the same condition.
- Load-use stall:
  - D holds its payload, d_allow_in=0 (fetch freezes), d_to_e_valid=0 (bubble into E).
  - Stall releases the cycle hazard deasserts; no extra latency.
- Latency: one cycle from fetch to d_* outputs. d_src1/d_src2 are combinational from the registered rs indices.
- Register file:
  - Write at posedge when w_en && w_rd!=0. Writes to x0 are ignored; x0 always reads 0.
  - Write-through bypass: if w_en && w_rd!=0 && w_rd==d_rsN, d_srcN=w_data in that same cycle. Otherwise d_srcN = array content.
  - Writes proceed regardless of d_valid, stall or flush.
- Reset mid-operation wins over flush/stall/write in that cycle. Outputs are undefined only before the first reset.

Test Plan:
1. Reset: rst=1 one cycle -> d_valid=0, d_to_e_valid=0, d_allow_in=1, d_instr=0x00000013; read x1..x31 all 0.
2. Pass-through: write x5=0x00001234; present addi x6,x5,1 (0x00128313, f_pc=0x80000000), e_allow_in=1 -> next cycle d_to_e_valid=1, d_rs1=5, d_rd=6, d_imm=1, d_src1=0x00001234, d_default_pc=0x80000004, d_reg_we=1.
3. Bypass: D holds add x8,x7,x0 while w_en=1, w_rd=7, w_data=0xDEADBEEF -> d_src1=0xDEADBEEF same cycle; w_en=1, w_rd=0, w_data=0xFFFFFFFF -> x0 still reads 0.
4. Load-use: D holds add x3,x1,x2; e_valid=1, e_is_load=1, e_rd=2 -> d_to_e_valid=0, d_allow_in=0, payload stable 2 cycles; drop e_is_load -> d_to_e_valid=1 that cycle. e_rd=0 -> no stall.
5. Flush: D valid, f_to_d_valid=1, e_valid=1, can_jump=1 -> d_to_e_valid=0 immediately, d_valid=0 next cycle, fetch payload not captured; repeat during a load-use stall -> d_valid cleared.
6. Back-pressure: e_allow_in=0 for 3 cycles with f_to_d_valid=1 -> d_allow_in=0, d_to_e_valid=1, all d_* stable; release -> new instruction captured next edge.
